// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: scanner col/row bus plus press-command handshake
interface keypad_emulator_if #(
    parameter int HOLD_W = 16
);
    logic [3:0]        col;
    logic [3:0]        row;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              contact;
    logic              busy;
    logic              press_done;
    modport master (
        output col, cmd_valid, cmd_key, cmd_hold,
        input  row, cmd_ready, contact, busy, press_done
    );
    modport slave (
        input  col, cmd_valid, cmd_key, cmd_hold,
        output row, cmd_ready, contact, busy, press_done
    );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix-keypad model with timed presses; KEYEMU_BOUNCE_EN enables LFSR contact bounce
module keypad_emulator #(
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          HOLD_W        = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input logic              clk,
    input logic              reset,
    keypad_emulator_if.slave s
);
    localparam int CW = (HOLD_W > $clog2(BOUNCE_CYCLES)) ? HOLD_W : $clog2(BOUNCE_CYCLES);
    typedef enum logic [1:0] {IDLE, MAKE, HOLD, BRK} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [3:0]        key_l, key_n;
    logic [HOLD_W-1:0] hold_l, hold_n;
    logic              done, done_n;
    logic              contact_w;
    // state, counter, latched command and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            key_l  <= '0;
            hold_l <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            key_l  <= key_n;
            hold_l <= hold_n;
            done   <= done_n;
        end
    end
    // sequence IDLE -> MAKE -> HOLD -> BREAK -> IDLE; each phase ends when the counter reaches 0
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        key_n   = key_l;
        hold_n  = hold_l;
        done_n  = 1'b0;
        case (state)
            IDLE: if (s.cmd_valid) begin
                state_n = MAKE;
                cnt_n   = CW'(BOUNCE_CYCLES - 1);
                key_n   = s.cmd_key;
                hold_n  = s.cmd_hold;
            end
            MAKE: if (cnt == '0) begin
                state_n = HOLD;
                cnt_n   = (hold_l == '0) ? '0 : CW'(hold_l) - CW'(1);
            end else cnt_n = cnt - CW'(1);
            HOLD: if (cnt == '0) begin
                state_n = BRK;
                cnt_n   = CW'(BOUNCE_CYCLES - 1);
            end else cnt_n = cnt - CW'(1);
            default: if (cnt == '0) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else cnt_n = cnt - CW'(1);
        endcase
    end
`ifdef KEYEMU_BOUNCE_EN
    logic [7:0] lfsr;
    // x^8+x^6+x^5+x^4+1 bounce source, stepping only during MAKE and BREAK
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else if (state == MAKE || state == BRK) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign contact_w = (state == HOLD) || ((state == MAKE || state == BRK) && lfsr[0]);
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign contact_w = (state == MAKE) || (state == HOLD);
`endif
    assign s.contact    = contact_w;
    assign s.busy       = (state != IDLE);
    assign s.cmd_ready  = (state == IDLE);
    assign s.press_done = done;
    // only the latched key connects its column to its row
    always_comb begin
        s.row = '0;
        s.row[key_l[3:2]] = contact_w && s.col[key_l[1:0]];
    end
endmodule
